// File: rtl/uart_frame_pkg.sv
// Shared frame constants for the UART frame transmitter and receiver.
// Keeping header/length definitions here stops the two ends from diverging.
// Optional checksum byte is controlled by the UART_FRAME_CHKSUM_EN macro.
package uart_frame_pkg;

    // Frame-level state encodings
    localparam logic [2:0] ENC_IDLE = 3'd0;
    localparam logic [2:0] ENC_HEAD = 3'd1;
    localparam logic [2:0] ENC_DATA = 3'd2;
    localparam logic [2:0] ENC_CHK  = 3'd3;
    localparam logic [2:0] ENC_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ENC_IDLE,
        HEAD = ENC_HEAD,
        DATA = ENC_DATA,
        CHK  = ENC_CHK,
        DONE = ENC_DONE
    } frame_state_t;

    localparam logic [7:0] FRAME_HEAD_BYTE = 8'hFF;
    localparam int         HEAD_LEN        = 2;
    localparam int         DATA_LEN        = 4;
    // start + 8 data + stop
    localparam int         UART_BITS       = 10;

    // Running checksum step: plain 8-bit add, carries discarded
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer: start bit 0, 8 data bits LSB first, stop bit 1.
// Each bit lasts BAUD_CNT_MAX clocks; byte_done marks the last stop-bit cycle.
// tx comes straight from a flop so the line never glitches.
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int BAUD_CNT_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_start,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       tx
);

    localparam int CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(UART_BITS - 1);

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q,  bit_d;
    logic [8:0]    shf_q,  shf_d;   // remaining bits: data then stop fill
    logic          act_q,  act_d;
    logic          tx_q,   tx_d;

    assign byte_done = act_q && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);
    assign tx        = tx_q;

    // Next-state: load on byte_start, otherwise advance one bit every baud period
    always_comb begin
        baud_d = baud_q;
        bit_d  = bit_q;
        shf_d  = shf_q;
        act_d  = act_q;
        tx_d   = tx_q;
        if (byte_start) begin
            baud_d = '0;
            bit_d  = '0;
            shf_d  = {1'b1, byte_data};
            act_d  = 1'b1;
            tx_d   = 1'b0;
        end else if (act_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == BIT_LAST) begin
                    act_d = 1'b0;
                    tx_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = shf_q[0];
                    shf_d = {1'b1, shf_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // Serializer registers; line idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q <= '0;
            bit_q  <= '0;
            shf_q  <= '0;
            act_q  <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            shf_q  <= shf_d;
            act_q  <= act_d;
            tx_q   <= tx_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: on an accepted send, emits FF FF then the 32-bit
// word MSB byte first, each byte 8N1, with a one-clock gap between bytes.
// Define UART_FRAME_CHKSUM_EN to append an 8-bit sum of the data bytes.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;

    frame_state_t state_q, state_d;
    logic [1:0]   cnt_q,   cnt_d;    // byte index within HEAD / DATA
    logic [31:0]  data_q,  data_d;   // shifts left one byte per data byte sent
    logic         start_q, start_d;  // byte_start pulse to the serializer
    logic [7:0]   byte_val;
    logic         byte_done;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]   chk_q,   chk_d;
`endif

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

    // Frame sequencing; next byte_start lands the cycle after byte_done
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        start_d  = 1'b0;
        byte_val = FRAME_HEAD_BYTE;
`ifdef UART_FRAME_CHKSUM_EN
        chk_d    = chk_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (send) begin
                    state_d = HEAD;
                    data_d  = data_in;
                    cnt_d   = '0;
                    start_d = 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            HEAD: begin
                byte_val = FRAME_HEAD_BYTE;
                if (byte_done) begin
                    start_d = 1'b1;
                    if (cnt_q == 2'(HEAD_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                byte_val = data_q[31:24];
                if (byte_done) begin
                    data_d = {data_q[23:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;   // wraps 3->0 on exit
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d  = chk_add(chk_q, data_q[31:24]);
`endif
                    if (cnt_q == 2'(DATA_LEN - 1)) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_d = CHK;
                        start_d = 1'b1;
`else
                        state_d = DONE;
`endif
                    end else begin
                        start_d = 1'b1;
                    end
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            CHK: begin
                byte_val = chk_q;
                if (byte_done) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= start_d;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    uart_byte_tx #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_byte (
        .clk        (clk),
        .reset      (reset),
        .byte_start (start_q),
        .byte_data  (byte_val),
        .byte_done  (byte_done),
        .tx         (tx)
    );

endmodule
